// File: rtl/logic_issue_arbiter_pkg.sv
// logic_issue_arbiter_pkg
//   Shared definitions for the logic-unit issue arbiter: default data width,
//   logic control codes, FSM state encoding and the round-robin pick helper.
package logic_issue_arbiter_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned MSB_CTRL       = 2;
  localparam int unsigned IMM_WIDTH      = 21;

  // Logic unit control codes; 3'b011 and 3'b111 are unused by the unit.
  localparam logic [MSB_CTRL:0] CTRL_AND  = 3'b000;
  localparam logic [MSB_CTRL:0] CTRL_OR   = 3'b001;
  localparam logic [MSB_CTRL:0] CTRL_XOR  = 3'b010;
  localparam logic [MSB_CTRL:0] CTRL_ANDI = 3'b100;
  localparam logic [MSB_CTRL:0] CTRL_ORI  = 3'b101;
  localparam logic [MSB_CTRL:0] CTRL_XORI = 3'b110;

  typedef enum logic [1:0] {
    LIA_IDLE  = 2'b00,
    LIA_ISSUE = 2'b01,
    LIA_EXEC  = 2'b10,
    LIA_OUT   = 2'b11
  } lia_state_e;

  // One-hot 2-way round-robin pick: on contention the requester that did
  // not win last time gets the grant.
  function automatic logic [1:0] rr_pick(input logic [1:0] valid,
                                         input logic       last_grant);
    logic [1:0] gnt;
    gnt = '0;
    if (valid == 2'b11) gnt = last_grant ? 2'b01 : 2'b10;
    else                gnt = valid;
    return gnt;
  endfunction

endpackage

// File: rtl/logic_issue_arbiter_if.sv
// logic_issue_arbiter_if
//   Requester and result handshake bundle of logic_issue_arbiter.
//   master : issue stage / consumer side (drives requests and res_ready)
//   slave  : arbiter side (drives reqN_ready and res_*)
interface logic_issue_arbiter_if
  import logic_issue_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned TAG_WIDTH  = 4
);

  logic                  req0_valid;
  logic                  req0_ready;
  logic [MSB_CTRL:0]     req0_type;
  logic [DATA_WIDTH-1:0] req0_src1;
  logic [DATA_WIDTH-1:0] req0_src2;
  logic [IMM_WIDTH-1:0]  req0_imm;
  logic [TAG_WIDTH-1:0]  req0_tag;

  logic                  req1_valid;
  logic                  req1_ready;
  logic [MSB_CTRL:0]     req1_type;
  logic [DATA_WIDTH-1:0] req1_src1;
  logic [DATA_WIDTH-1:0] req1_src2;
  logic [IMM_WIDTH-1:0]  req1_imm;
  logic [TAG_WIDTH-1:0]  req1_tag;

  logic                  res_valid;
  logic                  res_ready;
  logic [DATA_WIDTH-1:0] res_data;
  logic [TAG_WIDTH-1:0]  res_tag;
  logic                  res_src;

  modport master (
    output req0_valid, req0_type, req0_src1, req0_src2, req0_imm, req0_tag,
    output req1_valid, req1_type, req1_src1, req1_src2, req1_imm, req1_tag,
    input  req0_ready, req1_ready,
    input  res_valid, res_data, res_tag, res_src,
    output res_ready
  );

  modport slave (
    input  req0_valid, req0_type, req0_src1, req0_src2, req0_imm, req0_tag,
    input  req1_valid, req1_type, req1_src1, req1_src2, req1_imm, req1_tag,
    output req0_ready, req1_ready,
    output res_valid, res_data, res_tag, res_src,
    input  res_ready
  );

endinterface

// File: rtl/logic_rr_arbiter.sv
// logic_rr_arbiter
//   2-way grant generator for logic_issue_arbiter.
//   clk, reset : clock, asynchronous active-low reset
//   en         : an accept is allowed this cycle
//   valid[1:0] : requester valids
//   gnt[1:0]   : one-hot grant (zero when disabled or nothing valid)
//   Build option LOGIC_ARB_FIXED_PRIO_EN: requester 0 always wins and no
//   last_grant pointer exists (clk/reset then unused).
module logic_rr_arbiter
  import logic_issue_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] gnt
);

`ifdef LOGIC_ARB_FIXED_PRIO_EN

  always_comb begin
    gnt = '0;
    if (en) gnt = valid[0] ? 2'b01 : {valid[1], 1'b0};
  end

`else

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    gnt = '0;
    if (en) gnt = rr_pick(valid, last_grant_q);
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (|gnt) last_grant_d = gnt[1];
  end

  // Resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_grant_q <= 1'b1;
    else        last_grant_q <= last_grant_d;
  end

`endif

endmodule

// File: rtl/logic_issue_arbiter.sv
// logic_issue_arbiter
//   Shares one logical_unit between two requesters. Round-robin accept,
//   op register feeding the unit, ISSUE/EXEC sequencing, registered result
//   buffer with valid/ready. Accept-to-res_valid latency is 3 cycles.
//   clk           : clock
//   reset         : asynchronous active-low reset
//   bus (slave)   : req0/req1 valid/ready + payload, res valid/ready + data
//   lu_*          : operation to the logical unit (always from op register)
//   lu_result     : unit result, sampled only in EXEC
//   busy          : FSM not idle
//   Build option LOGIC_ARB_FIXED_PRIO_EN (handled in logic_rr_arbiter).
//   bus parameters must match DATA_WIDTH/TAG_WIDTH of this module.
module logic_issue_arbiter
  import logic_issue_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned TAG_WIDTH  = 4
)(
  input  logic                  clk,
  input  logic                  reset,
  logic_issue_arbiter_if.slave  bus,
  output logic [MSB_CTRL:0]     lu_logic_type,
  output logic [DATA_WIDTH-1:0] lu_src1,
  output logic [DATA_WIDTH-1:0] lu_src2,
  output logic [IMM_WIDTH-1:0]  lu_immediate,
  input  logic [DATA_WIDTH-1:0] lu_result,
  output logic                  busy
);

  lia_state_e state_q, state_d;

  logic [MSB_CTRL:0]     type_q, type_d;
  logic [DATA_WIDTH-1:0] src1_q, src1_d;
  logic [DATA_WIDTH-1:0] src2_q, src2_d;
  logic [IMM_WIDTH-1:0]  imm_q,  imm_d;
  logic [TAG_WIDTH-1:0]  tag_q,  tag_d;
  logic                  id_q,   id_d;

  logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic [TAG_WIDTH-1:0]  res_tag_q,  res_tag_d;
  logic                  res_src_q,  res_src_d;

  logic       accept_en;
  logic [1:0] gnt;
  logic       accept;

  // Accepts are blocked while reset is held so reqN_ready reads 0 even
  // though the state register already sits in IDLE.
  always_comb begin
    accept_en = 1'b0;
    if (reset) begin
      accept_en = (state_q == LIA_IDLE) ||
                  ((state_q == LIA_OUT) && bus.res_ready);
    end
  end

  logic_rr_arbiter u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (accept_en),
    .valid ({bus.req1_valid, bus.req0_valid}),
    .gnt   (gnt)
  );

  assign accept         = |gnt;
  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LIA_IDLE:  if (accept) state_d = LIA_ISSUE;
      LIA_ISSUE: state_d = LIA_EXEC;
      LIA_EXEC:  state_d = LIA_OUT;
      LIA_OUT:   if (bus.res_ready) state_d = accept ? LIA_ISSUE : LIA_IDLE;
      default:   state_d = LIA_IDLE;
    endcase
  end

  always_comb begin
    type_d = type_q;
    src1_d = src1_q;
    src2_d = src2_q;
    imm_d  = imm_q;
    tag_d  = tag_q;
    id_d   = id_q;
    if (accept) begin
      if (gnt[1]) begin
        type_d = bus.req1_type;
        src1_d = bus.req1_src1;
        src2_d = bus.req1_src2;
        imm_d  = bus.req1_imm;
        tag_d  = bus.req1_tag;
        id_d   = 1'b1;
      end else begin
        type_d = bus.req0_type;
        src1_d = bus.req0_src1;
        src2_d = bus.req0_src2;
        imm_d  = bus.req0_imm;
        tag_d  = bus.req0_tag;
        id_d   = 1'b0;
      end
    end
  end

  // Result buffer loads only in EXEC, so an op accepted in OUT cannot
  // disturb the result being handed over in the same cycle.
  always_comb begin
    res_data_d = res_data_q;
    res_tag_d  = res_tag_q;
    res_src_d  = res_src_q;
    if (state_q == LIA_EXEC) begin
      res_data_d = lu_result;
      res_tag_d  = tag_q;
      res_src_d  = id_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= LIA_IDLE;
      type_q     <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      imm_q      <= '0;
      tag_q      <= '0;
      id_q       <= 1'b0;
      res_data_q <= '0;
      res_tag_q  <= '0;
      res_src_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      imm_q      <= imm_d;
      tag_q      <= tag_d;
      id_q       <= id_d;
      res_data_q <= res_data_d;
      res_tag_q  <= res_tag_d;
      res_src_q  <= res_src_d;
    end
  end

  assign lu_logic_type = type_q;
  assign lu_src1       = src1_q;
  assign lu_src2       = src2_q;
  assign lu_immediate  = imm_q;

  assign bus.res_valid = (state_q == LIA_OUT);
  assign bus.res_data  = res_data_q;
  assign bus.res_tag   = res_tag_q;
  assign bus.res_src   = res_src_q;
  assign busy          = (state_q != LIA_IDLE);

endmodule

// File: tb/tb_logic_issue_arbiter.sv
// tb_logic_issue_arbiter
//   Directed + random bench for logic_issue_arbiter with a transaction-level
//   reference (cycles since accept, pending expected result, grant pointer)
//   and a behavioural logical_unit (registered sources, combinational select).
module tb_logic_issue_arbiter;
  import logic_issue_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  lu_logic_type;
  logic [31:0] lu_src1, lu_src2, lu_result;
  logic [20:0] lu_immediate;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  logic_issue_arbiter_if #(.DATA_WIDTH(32), .TAG_WIDTH(4)) bus ();

  logic_issue_arbiter #(.DATA_WIDTH(32), .TAG_WIDTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .lu_logic_type (lu_logic_type),
    .lu_src1       (lu_src1),
    .lu_src2       (lu_src2),
    .lu_immediate  (lu_immediate),
    .lu_result     (lu_result),
    .busy          (busy)
  );

  // Logic operation as defined for the unit; immediate is zero-extended.
  function automatic logic [31:0] ref_lu(input logic [2:0] t, input logic [31:0] a,
                                         input logic [31:0] b, input logic [20:0] imm);
    logic [31:0] z;
    z = {11'b0, imm};
    case (t)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd4:    return a & z;
      3'd5:    return a | z;
      3'd6:    return a ^ z;
      default: return 32'h0;
    endcase
  endfunction

  // logical_unit model: sources registered each cycle, select combinational.
  logic [31:0] u_a, u_b;
  logic [20:0] u_imm;
  always @(posedge clk) begin
    u_a   <= lu_src1;
    u_b   <= lu_src2;
    u_imm <= lu_immediate;
  end
  assign lu_result = ref_lu(lu_logic_type, u_a, u_b, u_imm);

  // Reference: m_age = cycles since the accepted op (0 = nothing in flight,
  // result visible from 3 until taken).
  int          m_age;
  logic        m_last;
  logic [2:0]  p_type;
  logic [31:0] p_src1, p_src2, p_data;
  logic [20:0] p_imm;
  logic [3:0]  p_tag;
  logic        p_src;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int n, input logic v, input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] b, input logic [20:0] imm, input logic [3:0] tag);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_type = t; bus.req0_src1 = a;
      bus.req0_src2 = b; bus.req0_imm = imm; bus.req0_tag = tag;
    end else begin
      bus.req1_valid = v; bus.req1_type = t; bus.req1_src1 = a;
      bus.req1_src2 = b; bus.req1_imm = imm; bus.req1_tag = tag;
    end
  endtask

  task automatic rand_req(input int n, input logic v);
    set_req(n, v, 3'($urandom_range(0, 7)), $urandom, $urandom, 21'($urandom), 4'($urandom));
  endtask

  task automatic model_reset();
    m_age  = 0;
    m_last = 1'b1;
  endtask

  // One clock cycle: inputs are already applied (at posedge+1).
  task automatic cyc();
    logic       free;
    logic [1:0] v, eg;
    #1;
    v    = {bus.req1_valid, bus.req0_valid};
    free = (m_age == 0) || (m_age >= 3 && bus.res_ready);
    eg   = '0;
    if (free) begin
`ifdef LOGIC_ARB_FIXED_PRIO_EN
      if (v[0]) eg = 2'b01;
      else if (v[1]) eg = 2'b10;
`else
      if (v == 2'b11) eg = m_last ? 2'b01 : 2'b10;
      else eg = v;
`endif
    end
    chk("req0_ready", bus.req0_ready, eg[0]);
    chk("req1_ready", bus.req1_ready, eg[1]);
    chk("busy", busy, m_age != 0);
    chk("res_valid", bus.res_valid, m_age >= 3);
    if (m_age >= 3) begin
      chk("res_data", bus.res_data, p_data);
      chk("res_tag", bus.res_tag, p_tag);
      chk("res_src", bus.res_src, p_src);
    end
    if (m_age == 1 || m_age == 2) begin
      chk("lu_type", lu_logic_type, p_type);
      chk("lu_src1", lu_src1, p_src1);
      chk("lu_src2", lu_src2, p_src2);
      chk("lu_imm", lu_immediate, p_imm);
    end
    @(posedge clk);
    if (|eg) begin
      if (eg[1]) begin
        p_type = bus.req1_type; p_src1 = bus.req1_src1; p_src2 = bus.req1_src2;
        p_imm = bus.req1_imm; p_tag = bus.req1_tag; p_src = 1'b1;
      end else begin
        p_type = bus.req0_type; p_src1 = bus.req0_src1; p_src2 = bus.req0_src2;
        p_imm = bus.req0_imm; p_tag = bus.req0_tag; p_src = 1'b0;
      end
      p_data = ref_lu(p_type, p_src1, p_src2, p_imm);
      m_age  = 1;
      m_last = eg[1];
    end else if (m_age >= 3 && bus.res_ready) begin
      m_age = 0;
    end else if (m_age != 0 && m_age < 3) begin
      m_age++;
    end
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req0_ready"}, bus.req0_ready, 1'b0);
    chk({tag, "_req1_ready"}, bus.req1_ready, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_res_valid"}, bus.res_valid, 1'b0);
    chk({tag, "_res_data"}, bus.res_data, 32'h0);
    chk({tag, "_res_tag"}, bus.res_tag, 4'h0);
    chk({tag, "_res_src"}, bus.res_src, 1'b0);
    chk({tag, "_lu_type"}, lu_logic_type, 3'h0);
    chk({tag, "_lu_src1"}, lu_src1, 32'h0);
    chk({tag, "_lu_src2"}, lu_src2, 32'h0);
    chk({tag, "_lu_imm"}, lu_immediate, 21'h0);
  endtask

  initial begin
    model_reset();
    p_type = '0; p_src1 = '0; p_src2 = '0; p_imm = '0; p_tag = '0; p_src = 1'b0; p_data = '0;
    reset = 1'b0;
    bus.res_ready = 1'b0;
    set_req(0, 1'b1, CTRL_AND, 32'h1, 32'h2, 21'h3, 4'h1);
    set_req(1, 1'b1, CTRL_OR, 32'h4, 32'h5, 21'h6, 4'h2);

    // Reset values, with both valids high.
    #12;
    chk_all_zero("rst");
    @(posedge clk); #1;
    reset = 1'b1;

    // Single request, accepted in the first cycle out of reset.
    set_req(0, 1'b1, CTRL_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 21'h0, 4'd3);
    bus.req1_valid = 1'b0;
    bus.res_ready  = 1'b1;
    cyc();
    bus.req0_valid = 1'b0;
    cyc();
    cyc();
    chk("t1_res_valid", bus.res_valid, 1'b1);
    chk("t1_res_data", bus.res_data, 32'hF000_F000);
    chk("t1_res_tag", bus.res_tag, 4'd3);
    chk("t1_res_src", bus.res_src, 1'b0);
    cyc();

    // Contention: both valid continuously, result always taken.
    for (int i = 0; i < 12; i++) begin
      rand_req(0, 1'b1);
      rand_req(1, 1'b1);
      cyc();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (4) cyc();

    // Backpressure: result held while req1 waits.
    set_req(0, 1'b1, CTRL_XOR, 32'hAAAA_5555, 32'h0F0F_0F0F, 21'h0, 4'd7);
    cyc();
    bus.req0_valid = 1'b0;
    bus.res_ready  = 1'b0;
    set_req(1, 1'b1, CTRL_ANDI, 32'hFFFF_FFFF, 32'h0, 21'h1_2345, 4'd8);
    repeat (7) cyc();
    chk("bp_req1_ready", bus.req1_ready, 1'b0);
    bus.res_ready = 1'b1;
    cyc();
    bus.req1_valid = 1'b0;
    repeat (4) cyc();

    // Immediate op; lu_logic_type held through ISSUE and EXEC.
    set_req(1, 1'b1, CTRL_ORI, 32'h1234_0000, 32'hDEAD_BEEF, 21'h1_00FF, 4'd5);
    cyc();
    bus.req1_valid = 1'b0;
    chk("t4_lu_type_issue", lu_logic_type, CTRL_ORI);
    cyc();
    chk("t4_lu_type_exec", lu_logic_type, CTRL_ORI);
    cyc();
    chk("t4_res_data", bus.res_data, 32'h1235_00FF);
    chk("t4_res_src", bus.res_src, 1'b1);
    cyc();

    // Reset asserted during EXEC.
    set_req(0, 1'b1, CTRL_OR, 32'h1111_0000, 32'h0000_2222, 21'h0, 4'd6);
    cyc();
    bus.req0_valid = 1'b0;
    cyc();
    set_req(0, 1'b1, CTRL_OR, 32'h3, 32'h4, 21'h0, 4'd2);
    set_req(1, 1'b1, CTRL_OR, 32'h5, 32'h6, 21'h0, 4'd4);
    reset = 1'b0;
    #1;
    chk_all_zero("midrst");
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (4) cyc();
    set_req(0, 1'b1, CTRL_XORI, 32'h0000_FFFF, 32'h0, 21'h0_00FF, 4'd9);
    cyc();
    bus.req0_valid = 1'b0;
    repeat (4) cyc();

    // Unsupported type code, then an immediate follow-up request.
    set_req(1, 1'b1, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 21'h1F_FFFF, 4'd10);
    cyc();
    bus.req1_valid = 1'b0;
    cyc();
    cyc();
    chk("t6_res_data", bus.res_data, 32'h0);
    chk("t6_res_tag", bus.res_tag, 4'd10);
    set_req(0, 1'b1, CTRL_AND, 32'h0F0F_0000, 32'hFFFF_0000, 21'h0, 4'd11);
    cyc();
    bus.req0_valid = 1'b0;
    repeat (4) cyc();

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      rand_req(0, 1'($urandom_range(0, 1)));
      rand_req(1, 1'($urandom_range(0, 1)));
      bus.res_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.res_ready  = 1'b1;
    repeat (5) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/logic_issue_arbiter.md
# logic_issue_arbiter

Issue controller that shares the single `logical_unit` between two execution requesters. It arbitrates valid/ready requests round-robin, latches the winning operation, and sequences the unit's registered-source / combinational-select pipeline. It returns the tagged result through an output buffer with a valid/ready handshake. It sits between the issue stage and the logical unit inside the execution cluster.

## Interface
Parameters:
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (32): operand and result width.
- `TAG_WIDTH`, default 4: opaque requester tag, returned unchanged with the result.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: asynchronous, active-low. All state clears while `reset`=0.
- `reqN_valid` in 1, N=0,1: requester N presents an operation.
- `reqN_ready` out 1: arbiter accepts requester N this cycle.
- `reqN_type` in 3: logic control code (`` `CTRL_AND `` … `` `CTRL_XORI ``).
- `reqN_src1`, `reqN_src2` in DATA_WIDTH: operands.
- `reqN_imm` in 21: immediate.
- `reqN_tag` in TAG_WIDTH: tag.
- `lu_logic_type` out 3: control code to the unit.
- `lu_src1`, `lu_src2` out DATA_WIDTH: operands to the unit.
- `lu_immediate` out 21: immediate to the unit.
- `lu_result` in DATA_WIDTH: `logical_value` from the unit.
- `res_valid` out 1: result buffer holds a result.
- `res_ready` in 1: consumer takes the result.
- `res_data` out DATA_WIDTH: result value.
- `res_tag` out TAG_WIDTH: tag of the operation.
- `res_src` out 1: requester id, 0 or 1.
- `busy` out 1: state is not IDLE.

## Operation
- FSM states:
  - IDLE: accepts a request.
  - ISSUE: `lu_*` driven from the op register; the unit captures its sources at the end of this cycle.
  - EXEC: `lu_logic_type` is still held, `lu_result` is valid, and the result buffer loads at the end of the cycle.
  - OUT: `res_valid`=1.
- Transitions:
  - IDLE→ISSUE on an accept.
  - ISSUE→EXEC unconditionally.
  - EXEC→OUT unconditionally.
  - OUT→IDLE on `res_ready` with no accept.
  - OUT→ISSUE on `res_ready` with an accept in the same cycle.
- Accept rules:
  - An accept is allowed only in IDLE, or in OUT with `res_ready`=1.
  - At most one `reqN_ready` is high per cycle. The request is taken when `reqN_valid`&`reqN_ready`.
- `reqN_ready` is a function of the valids and state. It asserts only when the corresponding valid is high.
- Arbitration: the `last_grant` pointer resets to 1.
  - Both valid: grant `!last_grant`.
  - One valid: grant that requester.
  - `last_grant` updates on every accept.
- Op register: on accept it loads type, src1, src2, imm, tag and source id. It is otherwise held.
- `lu_*` outputs come from the op register in all states. They are never taken directly from the requester inputs.
- Unsupported type codes are forwarded unchanged. The unit returns 0, which is passed as a normal result.
- Reset values:
  - `res_valid`=0, `busy`=0, `reqN_ready`=0 while in reset.
  - `res_data`=0, `res_tag`=0, `res_src`=0.
  - `lu_logic_type`=0, `lu_src1`/`lu_src2`/`lu_immediate`=0.
  - FSM state = IDLE.
- Reset mid-operation: the in-flight operation is discarded with no result, and the FSM returns to IDLE.
- Reset release: the first accept can occur in the first cycle with `reset`=1.

## Timing
- Accept at cycle T:
  - ISSUE in T+1.
  - EXEC in T+2.
  - `res_valid`=1 from T+3.
  - Latency is 3 cycles.
- Throughput: one operation per 3 cycles while `res_ready` is held high (back-to-back accept in OUT).
- `res_*` outputs stay stable while `res_valid`=1 and `res_ready`=0.
- No combinational path from `lu_result` to any output. `res_data` is registered.
- `reqN_ready` depends combinationally on `res_ready` in OUT.

## Configuration
- `LOGIC_ARB_FIXED_PRIO_EN`
  - Defined: requester 0 always wins when both are valid. `last_grant` is not implemented.
  - Undefined (default): round-robin as specified above.

## Structure
- Shared package/header (`Execution_param.vh`) holds:
  - the FSM state encoding `LIA_IDLE`/`LIA_ISSUE`/`LIA_EXEC`/`LIA_OUT` (2 bits);
  - the `` `CTRL_* `` codes;
  - `` `MSB_CTRL ``.
- Sub-module `logic_rr_arbiter`: a 2-way grant from the valids, the enable, and `last_grant`. The macro is handled inside it.
- Top level contains the FSM, op register and result buffer.

## Test plan
1. Single request: req0 valid with `CTRL_AND`, src1=0xF0F0_F0F0, src2=0xFF00_FF00, tag=3 at T; `res_ready`=1 → `res_valid` at T+3, `res_data`=0xF000_F000, `res_tag`=3, `res_src`=0.
2. Contention, round-robin: both requesters valid continuously, `res_ready`=1 → grants alternate 0,1,0,1, one accept every 3 cycles. With `LOGIC_ARB_FIXED_PRIO_EN` defined, all grants go to 0.
3. Backpressure: `res_ready`=0 for 5 cycles after the result arrives, req1 valid → `res_*` held and stable, `req1_ready`=0. Raising `res_ready` → req1 accepted in that same cycle.
4. Immediate op: `CTRL_ORI`, src1=0x1234_0000, imm=0x1_00FF → `res_data`=0x1235_00FF. `lu_logic_type` is held at `CTRL_ORI` through ISSUE and EXEC.
5. Reset mid-op: `reset` driven low during EXEC → all outputs zero immediately. After release, no stale result appears, and a new request gets latency 3.
6. Illegal type code 3'b011 → result 0 returned with its tag, and the FSM is not stalled.
